spi_slave_cmd_ctrl: RTL and testbench

//  Frame-level command controller behind the SPI slave byte shifter. Decodes the first byte of each
//  CS frame as a command: bit7=1 read, bit7=0 write, bits[6:0] register address. It then sequences

---
 rtl/spi_slave_cmd_ctrl_if.sv | 28 ++
 rtl/spi_slave_cmd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_spi_slave_cmd_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_cmd_ctrl_if.sv
// Bundle between the SPI command controller, the MISO/MOSI byte shifter and the register bank.
// master = controller view (drives the register bus and tx side), slave = the surrounding logic.
interface spi_slave_cmd_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              cs_active;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_byte;
  logic              tx_load;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr_en;
  logic [7:0]        reg_wdata;
  logic              reg_rd_en;
  logic [7:0]        reg_rdata;
  logic              err_addr;
  logic              err_ovr;

  modport master (
    input  cs_active, rx_valid, rx_byte, reg_rdata,
    output tx_byte, tx_load, reg_addr, reg_wr_en, reg_wdata, reg_rd_en, err_addr, err_ovr
  );

  modport slave (
    output cs_active, rx_valid, rx_byte, reg_rdata,
    input  tx_byte, tx_load, reg_addr, reg_wr_en, reg_wdata, reg_rd_en, err_addr, err_ovr
  );
endinterface

// File: rtl/spi_slave_cmd_ctrl.sv
// Frame-level SPI command decoder: first byte per CS frame is {rd, addr}, following bytes access
// the register bank. Define SPI_CMD_AUTOINC_EN to auto-increment reg_addr after each data byte.
module spi_slave_cmd_ctrl #(
  parameter int         ADDR_W    = 7,
  parameter int         REG_COUNT = 16,
  parameter logic [7:0] OOR_BYTE  = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_slave_cmd_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_ISSUE,
    RD_LOAD,
    RD_WAIT,
    WR_WAIT
  } state_t;

  localparam logic [ADDR_W:0] REG_COUNT_W = REG_COUNT[ADDR_W:0];
  localparam int              LAST_I      = REG_COUNT - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = LAST_I[ADDR_W-1:0];

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              oor_reg, oor_next;
  logic              err_addr_reg, err_addr_next;
  logic              err_ovr_reg, err_ovr_next;
  logic              echo_pend_reg, echo_pend_next;
  logic [7:0]        echo_byte_reg, echo_byte_next;
  logic [7:0]        tx_byte_reg, tx_byte_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic              cs_prev_reg;
  logic              load_strobe, wr_strobe, rd_strobe;
  logic              cmd_oor;
  logic [ADDR_W-1:0] addr_adv;

  assign cmd_oor = ({1'b0, bus.rx_byte[ADDR_W-1:0]} >= REG_COUNT_W);

`ifdef SPI_CMD_AUTOINC_EN
  // Out-of-range start addresses are frozen so the whole frame stays out of range.
  assign addr_adv = oor_reg ? addr_reg :
                    (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
`else
  assign addr_adv = addr_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      oor_reg       <= 1'b0;
      err_addr_reg  <= 1'b0;
      err_ovr_reg   <= 1'b0;
      echo_pend_reg <= 1'b0;
      echo_byte_reg <= 8'h00;
      tx_byte_reg   <= 8'h00;
      wdata_reg     <= 8'h00;
      // Treat cs as already high so a frame open across reset needs a fresh rising edge.
      cs_prev_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      oor_reg       <= oor_next;
      err_addr_reg  <= err_addr_next;
      err_ovr_reg   <= err_ovr_next;
      echo_pend_reg <= echo_pend_next;
      echo_byte_reg <= echo_byte_next;
      tx_byte_reg   <= tx_byte_next;
      wdata_reg     <= wdata_next;
      cs_prev_reg   <= bus.cs_active;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    oor_next       = oor_reg;
    err_addr_next  = err_addr_reg;
    err_ovr_next   = err_ovr_reg;
    echo_pend_next = 1'b0;
    echo_byte_next = echo_byte_reg;
    tx_byte_next   = tx_byte_reg;
    wdata_next     = wdata_reg;
    load_strobe    = 1'b0;
    wr_strobe      = 1'b0;
    rd_strobe      = 1'b0;

    // Chip-select low overrides everything: no strobes, address and tx byte held.
    if (!bus.cs_active) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!cs_prev_reg) begin
            state_next   = CMD;
            load_strobe  = 1'b1;
            tx_byte_next = {6'b0, err_addr_reg, err_ovr_reg};
          end
        end
        CMD: begin
          if (bus.rx_valid) begin
            addr_next = bus.rx_byte[ADDR_W-1:0];
            oor_next  = cmd_oor;
            if (bus.rx_byte[7]) begin
              state_next = RD_ISSUE;
            end else begin
              state_next     = WR_WAIT;
              echo_pend_next = 1'b1;
              echo_byte_next = bus.rx_byte;
            end
          end
        end
        RD_ISSUE: begin
          if (oor_reg) err_addr_next = 1'b1;
          else         rd_strobe     = 1'b1;
          if (bus.rx_valid) err_ovr_next = 1'b1;
          state_next = RD_LOAD;
        end
        RD_LOAD: begin
          load_strobe  = 1'b1;
          tx_byte_next = oor_reg ? OOR_BYTE : bus.reg_rdata;
          if (bus.rx_valid) err_ovr_next = 1'b1;
          state_next = RD_WAIT;
        end
        RD_WAIT: begin
          if (bus.rx_valid) begin
            addr_next  = addr_adv;
            state_next = RD_ISSUE;
          end
        end
        WR_WAIT: begin
          if (echo_pend_reg) begin
            load_strobe  = 1'b1;
            tx_byte_next = echo_byte_reg;
          end
          if (bus.rx_valid) begin
            if (oor_reg) begin
              err_addr_next = 1'b1;
            end else begin
              wr_strobe  = 1'b1;
              wdata_next = bus.rx_byte;
            end
            echo_pend_next = 1'b1;
            echo_byte_next = bus.rx_byte;
            addr_next      = addr_adv;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.tx_byte   = tx_byte_next;
  assign bus.tx_load   = load_strobe;
  assign bus.reg_addr  = addr_reg;
  assign bus.reg_wr_en = wr_strobe;
  assign bus.reg_wdata = wdata_next;
  assign bus.reg_rd_en = rd_strobe;
  assign bus.err_addr  = err_addr_reg;
  assign bus.err_ovr   = err_ovr_reg;

endmodule

// File: tb/tb_spi_slave_cmd_ctrl.sv
// Randomized frame-level bench for spi_slave_cmd_ctrl: a register bank responder plus a
// frame-rule reference model predicting tx bytes, bank accesses, their cycles and error flags.
module tb_spi_slave_cmd_ctrl;
  localparam int         RC  = 16;
  localparam logic [7:0] OOR = 8'hFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_cmd_ctrl_if #(.ADDR_W(7)) bus ();

  spi_slave_cmd_ctrl #(
    .ADDR_W   (7),
    .REG_COUNT(RC),
    .OOR_BYTE (OOR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Register bank with one-cycle read latency
  logic [7:0] bank [0:127];
  bit         bank_loaded = 1'b0;
  always @(posedge clk) begin
    if (!bank_loaded) begin
      for (int i = 0; i < 128; i++) bank[i] <= 8'(i * 29 + 7);
      bank_loaded <= 1'b1;
    end else begin
      if (bus.reg_wr_en) bank[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_rd_en) bus.reg_rdata <= bank[bus.reg_addr];
    end
  end

  // Observed activity
  logic [7:0]  tx_log[$];
  int          tx_cyc[$];
  logic [14:0] wr_log[$];
  int          wr_cyc[$];
  logic [6:0]  rd_log[$];
  int          rd_cyc[$];
  int          ns_mon;

  always @(negedge clk) begin
    if (rst) begin
      ns_mon = int'(bus.tx_load) + int'(bus.reg_wr_en) + int'(bus.reg_rd_en);
      if (ns_mon != 0) chk("strobe_exclusive", ns_mon, 1);
      if (bus.tx_load)   begin tx_log.push_back(bus.tx_byte);                 tx_cyc.push_back(cyc); end
      if (bus.reg_wr_en) begin wr_log.push_back({bus.reg_addr, bus.reg_wdata}); wr_cyc.push_back(cyc); end
      if (bus.reg_rd_en) begin rd_log.push_back(bus.reg_addr);                rd_cyc.push_back(cyc); end
    end
  end

  // Reference model state
  logic [7:0] ref_mem [0:15];
  bit         ref_ea, ref_eo;
  logic [7:0] dat [0:7];

  function automatic logic [6:0] addr_at(input logic [6:0] a0, input int i);
    int step;
    step = 0;
`ifdef SPI_CMD_AUTOINC_EN
    step = i;
`endif
    if (int'(a0) >= RC) return a0;
    return 7'((int'(a0) + step) % RC);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output int c);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    c            = cyc;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic clear_logs();
    tx_log.delete(); tx_cyc.delete();
    wr_log.delete(); wr_cyc.delete();
    rd_log.delete(); rd_cyc.delete();
  endtask

  // mode: 0 normal, 1 cs drops one cycle after the read command, 2 extra byte during a fetch,
  //       3 last write byte arrives in the same cycle cs drops
  task automatic run_frame(input logic [7:0] cmd, input int n, input int mode);
    logic [7:0]  etx[$];
    int          etc[$];
    logic [14:0] ewr[$];
    int          ewc[$];
    logic [6:0]  erd[$];
    int          erc[$];
    int          rxc [0:8];
    int          cs_cyc, nwr, nfetch, junk;
    logic [6:0]  a0, a, end_addr;
    bit          oor;

    a0  = cmd[6:0];
    oor = (int'(a0) >= RC);
    etx.push_back({6'b0, ref_ea, ref_eo});

    @(posedge clk);
    #1;
    clear_logs();
    bus.cs_active = 1'b1;
    cs_cyc        = cyc;
    etc.push_back(cs_cyc);
    wait_cyc(2);
    send(cmd, rxc[0]);
    if (mode == 1) begin
      bus.cs_active = 1'b0;
      wait_cyc(5);
    end else begin
      if (mode == 2) send(8'($urandom), junk);
      for (int i = 0; i < n; i++) begin
        wait_cyc($urandom_range(2, 6));
        if (mode == 3 && i == n - 1) bus.cs_active = 1'b0;
        send(dat[i], rxc[i+1]);
      end
      if (mode != 3) begin
        wait_cyc(5);
        bus.cs_active = 1'b0;
      end
      wait_cyc(3);
    end

    if (!cmd[7]) begin
      nwr = (mode == 3) ? n - 1 : n;
      etx.push_back(cmd);
      etc.push_back(rxc[0] + 1);
      for (int i = 0; i < nwr; i++) begin
        a = addr_at(a0, i);
        if (oor) begin
          ref_ea = 1'b1;
        end else begin
          ewr.push_back({a, dat[i]});
          ewc.push_back(rxc[i+1]);
          ref_mem[a[3:0]] = dat[i];
        end
        etx.push_back(dat[i]);
        etc.push_back(rxc[i+1] + 1);
      end
      end_addr = addr_at(a0, nwr);
    end else begin
      nfetch = (mode == 1) ? 0 : n + 1;
      if (mode == 2) ref_eo = 1'b1;
      for (int j = 0; j < nfetch; j++) begin
        a = addr_at(a0, j);
        if (oor) begin
          ref_ea = 1'b1;
          etx.push_back(OOR);
        end else begin
          erd.push_back(a);
          erc.push_back(rxc[j] + 1);
          etx.push_back(ref_mem[a[3:0]]);
        end
        etc.push_back(rxc[j] + 2);
      end
      end_addr = (mode == 1) ? a0 : addr_at(a0, n);
    end

    chk("tx_count", tx_log.size(), etx.size());
    for (int i = 0; i < etx.size(); i++) begin
      if (i < tx_log.size()) begin
        chk("tx_byte", tx_log[i], etx[i]);
        chk("tx_cycle", tx_cyc[i], etc[i]);
      end
    end
    chk("wr_count", wr_log.size(), ewr.size());
    for (int i = 0; i < ewr.size(); i++) begin
      if (i < wr_log.size()) begin
        chk("wr_addr_data", wr_log[i], ewr[i]);
        chk("wr_cycle", wr_cyc[i], ewc[i]);
      end
    end
    chk("rd_count", rd_log.size(), erd.size());
    for (int i = 0; i < erd.size(); i++) begin
      if (i < rd_log.size()) begin
        chk("rd_addr", rd_log[i], erd[i]);
        chk("rd_cycle", rd_cyc[i], erc[i]);
      end
    end
    chk("addr_hold", bus.reg_addr, end_addr);
    chk("err_addr", bus.err_addr, ref_ea);
    chk("err_ovr", bus.err_ovr, ref_eo);
    $display("frame cmd=%02h n=%0d mode=%0d tx=%0d wr=%0d rd=%0d err=%0d%0d",
             cmd, n, mode, tx_log.size(), wr_log.size(), rd_log.size(), ref_ea, ref_eo);
  endtask

  initial begin
    int         n, mode;
    logic [7:0] cmd;

    for (int i = 0; i < RC; i++) ref_mem[i] = 8'(i * 29 + 7);
    ref_ea        = 1'b0;
    ref_eo        = 1'b0;
    rst           = 1'b0;
    bus.cs_active = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_outputs",
          {bus.tx_byte, bus.tx_load, bus.reg_addr, bus.reg_wr_en, bus.reg_wdata,
           bus.reg_rd_en, bus.err_addr, bus.err_ovr}, 32'h0);
    end

    dat[0] = 8'hA5; dat[1] = 8'h5A;
    run_frame(8'h03, 2, 0);
    dat[0] = 8'h3C; dat[1] = 8'hC3;
    run_frame(8'h04, 1, 0);
    run_frame(8'h83, 2, 0);
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
    run_frame(8'h0F, 3, 0);
    run_frame(8'h90, 1, 0);
    run_frame(8'h85, 1, 1);
    run_frame(8'h81, 1, 2);
    dat[0] = 8'h66; dat[1] = 8'h77;
    run_frame(8'h02, 2, 3);

    for (int f = 0; f < 40; f++) begin
      cmd[7]   = 1'($urandom_range(0, 1));
      cmd[6:0] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(16, 127))
                                              : 7'($urandom_range(0, 15));
      n        = $urandom_range(0, 4);
      for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
      mode = 0;
      if ($urandom_range(0, 4) == 0) begin
        if (cmd[7])     mode = $urandom_range(1, 2);
        else if (n > 0) mode = 3;
      end
      run_frame(cmd, n, mode);
    end

    // Reset in the middle of an open frame; cs stays high afterwards
    @(posedge clk);
    #1;
    bus.cs_active = 1'b1;
    wait_cyc(2);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h05;
    wait_cyc(1);
    bus.rx_valid = 1'b0;
    rst          = 1'b0;
    wait_cyc(2);
    rst = 1'b1;
    clear_logs();
    ref_ea = 1'b0;
    ref_eo = 1'b0;
    wait_cyc(6);
    chk("midrst_quiet", tx_log.size() + wr_log.size() + rd_log.size(), 0);
    chk("midrst_flags", {bus.err_addr, bus.err_ovr}, 0);
    chk("midrst_addr", bus.reg_addr, 0);
    bus.cs_active = 1'b0;
    wait_cyc(3);
    dat[0] = 8'h00;
    run_frame(8'h84, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
